// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell time-shared over WIDTH cycles, LSB first.
// Start/busy/done handshake; result, cout and ovf hold until the next operation shifts in.
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sreg_a_q, sreg_a_d;
    logic [WIDTH-1:0]   sreg_b_q, sreg_b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               carry_q, carry_d;
    logic               cmsb_q, cmsb_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic s_bit, c_bit;

    assign s_bit = sreg_a_q[0] ^ sreg_b_q[0] ^ carry_q;
    assign c_bit = (sreg_a_q[0] & sreg_b_q[0]) | (sreg_a_q[0] & carry_q) |
                   (sreg_b_q[0] & carry_q);

    always_comb begin
        state_d  = state_q;
        sreg_a_d = sreg_a_q;
        sreg_b_d = sreg_b_q;
        result_d = result_q;
        count_d  = count_q;
        carry_d  = carry_q;
        cmsb_d   = cmsb_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    // Subtract as A + ~B + 1: invert B and seed the carry with op.
                    sreg_a_d = a;
                    sreg_b_d = b ^ {WIDTH{op}};
                    carry_d  = op;
                    count_d  = '0;
                    state_d  = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                result_d = {s_bit, result_q[WIDTH-1:1]};
                sreg_a_d = {1'b0, sreg_a_q[WIDTH-1:1]};
                sreg_b_d = {1'b0, sreg_b_q[WIDTH-1:1]};
                carry_d  = c_bit;
                count_d  = count_q + 1'b1;
                if (count_q == CNT_W'(WIDTH - 2)) begin
                    cmsb_d = c_bit;
                end
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = c_bit;
                    ovf_d   = cmsb_q ^ c_bit;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sreg_a_q <= '0;
            sreg_b_q <= '0;
            result_q <= '0;
            count_q  <= '0;
            carry_q  <= 1'b0;
            cmsb_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_a_q <= sreg_a_d;
            sreg_b_q <= sreg_b_d;
            result_q <= result_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            cmsb_q   <= cmsb_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
Bit-serial sequencer that time-shares a single full-adder cell to perform WIDTH-bit add or subtract, LSB first, one bit per clock. Subtract is implemented as A + ~B + 1: each B bit is XORed with the op bit and the carry is seeded with op. The block sits in front of the arithmetic datapath as its controller. It accepts operands with a start/busy/done handshake and returns sum, carry-out and signed overflow.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)
CNT_W, 3, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only in IDLE or DONE
op  input  1  0 = add, 1 = subtract; latched with start
a  input  WIDTH  operand A; latched with start
b  input  WIDTH  operand B; latched with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; result, cout and ovf are valid from this cycle
result  output  WIDTH  A+B or A-B, modulo 2^WIDTH
cout  output  1  final carry; in subtract mode 1 = no borrow (A >= B unsigned)
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Only one clock domain and one reset. Reset is synchronous, active-high: all state is cleared on any rising clk edge with rst=1.
- Reset values: state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, carry=0, count=0.
- States:
  - IDLE: if start=1, latch a into sreg_a, latch b^{WIDTH{op}} into sreg_b, set carry=op and count=0, go to RUN.
  - RUN: each cycle, the cell computes s = sreg_a[0]^sreg_b[0]^carry and c = majority(sreg_a[0], sreg_b[0], carry).
    - s shifts into the result register from the MSB end; sreg_a and sreg_b shift right; carry <= c; count increments.
    - On the cycle where count = WIDTH-2, also capture the carry-in to the MSB for ovf.
    - When count = WIDTH-1, go to DONE.
  - DONE: for one cycle only, done=1 and cout holds the final carry. From DONE, start=1 behaves exactly as in IDLE (back-to-back operations, no idle bubble). Otherwise go to IDLE.
- busy=1 exactly in RUN.
- Latency: start sampled at edge k. Result bits are produced at edges k+1 .. k+WIDTH. done is high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- result, cout and ovf hold their values after DONE until the next accepted start. They change only while the next operation is in RUN.
- start while busy=1 is ignored: no queueing, and in-flight operands are not disturbed.
- a, b and op are don't-care except in the cycle start is accepted.
- rst=1 mid-operation aborts immediately to IDLE. No done is generated and outputs are cleared.
- Arithmetic is modulo 2^WIDTH. In subtract mode, cout=0 means a borrow occurred.

Test Plan:
- WIDTH=4, op=1, a=1011, b=1001, start pulse -> busy for 4 cycles, then done with result=0010, cout=1, ovf=0 (11-9=2).
- op=0, a=1011, b=1001 -> result=0100, cout=1, ovf=1 (-5 + -7 overflows).
- op=1, a=0011, b=0101 -> result=1110, cout=0 (borrow), ovf=0; op=0, a=0111, b=0001 -> result=1000, cout=0, ovf=1.
- Assert start with new operands during the 2nd RUN cycle -> ignored; the first result is unchanged and exactly one done pulse occurs. Then assert start in the DONE cycle -> second operation starts with zero idle cycles and its done arrives 5 cycles later.
- Assert rst during the 3rd RUN cycle -> next cycle state=IDLE, busy=0, result=0, and no done pulse. A following op=0, a=0001, b=0001 gives result=0010.
- Random sweep: 200 random a, b, op at WIDTH=4 and WIDTH=8, checked against a reference model of a±b for result, cout and ovf, and against the exact done latency (start edge + WIDTH + 1).
